uart_rx_param: RTL and testbench

//  Parametrised UART receiver. Generalises the fixed 8N1 receiver:
//  - configurable data width, parity, stop bits and oversampling
//  - majority-vote bit sampling and false-start rejection
//  - parity, framing and overrun detection
//  - valid/ready output handshake

---
 rtl/uart_rx_param.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Purpose: parametrised oversampling UART receiver with majority-vote sampling and error flags.
// Latency: rx_valid rises 1 clk after the decision tick of the last stop bit.
// Backpressure: a held word waits for rx_ready; a frame that completes while it waits is dropped and sets overrun.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   RxD        asynchronous serial input, idle high
//   rx_data    received word, LSB = first data bit on the line
//   rx_valid   rx_data/parity_err/frame_err valid, held until rx_valid & rx_ready
//   rx_ready   consumer accept
//   parity_err parity mismatch for the held word
//   frame_err  a stop bit of the held word was sampled 0
//   overrun    sticky lost-frame flag, cleared on accept
//   busy       receiver FSM not idle
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    logic                 rxs_meta_q, rxs_meta_d;
    logic                 rxs_q, rxs_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic tick;
    logic vote;
    logic decide;
    logic bit_end;
    logic complete;

    always_comb begin
        rxs_meta_d   = RxD;
        rxs_d        = rxs_meta_q;
        tick_cnt_d   = tick_cnt_q;
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        vote_d       = vote_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        complete     = 1'b0;

        tick       = (tick_cnt_q == T_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

        // The third sample is the live rxs value at the decision tick.
        vote    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
        decide  = (s_cnt_q == S_V2);
        bit_end = (s_cnt_q == S_LAST);

        if (tick) begin
            if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
                s_cnt_d = bit_end ? '0 : s_cnt_q + SW'(1);
                if (s_cnt_q == S_V0) vote_d[0] = rxs_q;
                if (s_cnt_q == S_V1) vote_d[1] = rxs_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_d    = ST_START;
                        s_cnt_d    = '0;
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
                ST_START: begin
                    // A start bit that votes high was noise: drop it silently.
                    if (decide && vote) state_d = ST_IDLE;
                    else if (bit_end)   state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (decide) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == B_LAST)
                            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        else
                            bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        if (PARITY == 1) perr_d = ~(^shreg_q ^ vote);
                        else             perr_d = ^shreg_q ^ vote;
                    end
                    if (bit_end) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (decide) begin
                        if (!vote) ferr_d = 1'b1;
                        // Leave at mid-bit of the last stop bit so the next
                        // start edge is caught without a half-bit blind spot.
                        if (stop_cnt_q == STOP_LAST) begin
                            complete = 1'b1;
                            state_d  = vote ? ST_IDLE : ST_WAIT_HIGH;
                        end
                    end else if (bit_end) begin
                        stop_cnt_d = 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                parity_err_d = perr_q;
                frame_err_d  = ferr_q | ~vote;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxs_meta_q   <= 1'b1;
            rxs_q        <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            s_cnt_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            vote_q       <= 2'b11;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rxs_meta_q   <= rxs_meta_d;
            rxs_q        <= rxs_d;
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            vote_q       <= vote_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    // Scaled clocking keeps a frame to ~700 clk: 16x -> DIV 4, 8x -> DIV 8, bit = 64 clk.
    localparam int CLK_HZ  = 640_000;
    localparam int BAUD    = 10_000;
    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] rxd;
    logic [2:0] rdy;

    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [2:0] vld, perr, ferr, ovr, bsy;

    int n_vec = 0;
    int n_err = 0;

    int         hs_cnt  [3];
    int         vld_cyc [3];
    logic [8:0] cap_data[3];
    logic       cap_perr[3];
    logic       cap_ferr[3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .RxD(rxd[0]), .rx_data(d0), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
        .overrun(ovr[0]), .busy(bsy[0]));

    uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .RxD(rxd[1]), .rx_data(d1), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
        .overrun(ovr[1]), .busy(bsy[1]));

    uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(8),
                    .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .RxD(rxd[2]), .rx_data(d2), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
        .overrun(ovr[2]), .busy(bsy[2]));

    // Handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (vld[0]) vld_cyc[0]++;
        if (vld[1]) vld_cyc[1]++;
        if (vld[2]) vld_cyc[2]++;
        if (vld[0] && rdy[0]) begin
            hs_cnt[0]++; cap_data[0] = {1'b0, d0}; cap_perr[0] = perr[0]; cap_ferr[0] = ferr[0];
        end
        if (vld[1] && rdy[1]) begin
            hs_cnt[1]++; cap_data[1] = {1'b0, d1}; cap_perr[1] = perr[1]; cap_ferr[1] = ferr[1];
        end
        if (vld[2] && rdy[2]) begin
            hs_cnt[2]++; cap_data[2] = d2; cap_perr[2] = perr[2]; cap_ferr[2] = ferr[2];
        end
    end

    task automatic drive_bit(input int sel, input logic v);
        rxd[sel] = v;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] word, input int nbits,
                              input bit has_par, input logic pbit,
                              input int nstop, input logic stopv);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, word[i]);
        if (has_par) drive_bit(sel, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(sel, stopv);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (vld !== 3'b000) begin n_err++; $display("FAIL reset_valid got %b want 000", vld); end
        n_vec++; if (bsy !== 3'b000) begin n_err++; $display("FAIL reset_busy got %b want 000", bsy); end
        n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL reset_data0 got %h want 00", d0); end
        n_vec++; if ({perr, ferr, ovr} !== 9'h0) begin n_err++; $display("FAIL reset_flags got %b want 0", {perr, ferr, ovr}); end
        reset = 1'b0;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        n_vec++; if (bsy !== 3'b000) begin n_err++; $display("FAIL idle_busy got %b want 000", bsy); end
    endtask

    task automatic test_8n1();
        int h0, c0;
        h0 = hs_cnt[0]; c0 = vld_cyc[0];
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if (hs_cnt[0] - h0 != 1) begin n_err++; $display("FAIL 8n1_count got %0d want 1", hs_cnt[0] - h0); end
        n_vec++; if (vld_cyc[0] - c0 != 1) begin n_err++; $display("FAIL 8n1_pulse_len got %0d want 1", vld_cyc[0] - c0); end
        n_vec++; if (cap_data[0] !== 9'h0A5) begin n_err++; $display("FAIL 8n1_data got %h want 0a5", cap_data[0]); end
        n_vec++; if ({cap_perr[0], cap_ferr[0]} !== 2'b00) begin n_err++; $display("FAIL 8n1_flags got %b want 00", {cap_perr[0], cap_ferr[0]}); end
        n_vec++; if ({vld[0], ovr[0], bsy[0]} !== 3'b000) begin n_err++; $display("FAIL 8n1_after got %b want 000", {vld[0], ovr[0], bsy[0]}); end
    endtask

    task automatic test_glitch();
        int h0;
        h0 = hs_cnt[0];
        rxd[0] = 1'b0;
        repeat (15) @(posedge clk); #1;
        n_vec++; if (bsy[0] !== 1'b1) begin n_err++; $display("FAIL glitch_busy got %b want 1", bsy[0]); end
        repeat (10) @(posedge clk); #1;
        rxd[0] = 1'b1;
        repeat (BIT_CLK) @(posedge clk); #1;
        n_vec++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL glitch_idle got %b want 0", bsy[0]); end
        n_vec++; if (hs_cnt[0] != h0 || vld[0] !== 1'b0) begin n_err++; $display("FAIL glitch_word got %0d words want 0", hs_cnt[0] - h0); end
    endtask

    task automatic test_parity();
        int h1;
        h1 = hs_cnt[1];
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if (hs_cnt[1] - h1 != 1) begin n_err++; $display("FAIL par0_count got %0d want 1", hs_cnt[1] - h1); end
        n_vec++; if (cap_data[1] !== 9'h007) begin n_err++; $display("FAIL par0_data got %h want 007", cap_data[1]); end
        n_vec++; if ({cap_perr[1], cap_ferr[1]} !== 2'b10) begin n_err++; $display("FAIL par0_flags got %b want 10", {cap_perr[1], cap_ferr[1]}); end
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if (hs_cnt[1] - h1 != 2) begin n_err++; $display("FAIL par1_count got %0d want 2", hs_cnt[1] - h1); end
        n_vec++; if ({cap_perr[1], cap_ferr[1]} !== 2'b00) begin n_err++; $display("FAIL par1_flags got %b want 00", {cap_perr[1], cap_ferr[1]}); end
    endtask

    task automatic test_break();
        int h0;
        h0 = hs_cnt[0];
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
        n_vec++; if (hs_cnt[0] - h0 != 1) begin n_err++; $display("FAIL brk_count got %0d want 1", hs_cnt[0] - h0); end
        n_vec++; if (cap_data[0] !== 9'h055 || cap_ferr[0] !== 1'b1) begin n_err++; $display("FAIL brk_word got data %h ferr %b want 055 1", cap_data[0], cap_ferr[0]); end
        n_vec++; if (bsy[0] !== 1'b1) begin n_err++; $display("FAIL brk_wait_high got busy %b want 1", bsy[0]); end
        drive_bit(0, 1'b1);
        n_vec++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL brk_release got busy %b want 0", bsy[0]); end
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if (hs_cnt[0] - h0 != 2) begin n_err++; $display("FAIL brk_next_count got %0d want 2", hs_cnt[0] - h0); end
        n_vec++; if (cap_data[0] !== 9'h03C || {cap_perr[0], cap_ferr[0]} !== 2'b00) begin n_err++; $display("FAIL brk_next got data %h flags %b want 03c 00", cap_data[0], {cap_perr[0], cap_ferr[0]}); end
    endtask

    task automatic test_overrun();
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if ({vld[0], ovr[0]} !== 2'b10 || d0 !== 8'h11) begin n_err++; $display("FAIL ovr_first got v/o %b data %h want 10 11", {vld[0], ovr[0]}, d0); end
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if (d0 !== 8'h11) begin n_err++; $display("FAIL ovr_held_data got %h want 11", d0); end
        n_vec++; if ({vld[0], ovr[0]} !== 2'b11) begin n_err++; $display("FAIL ovr_flag got v/o %b want 11", {vld[0], ovr[0]}); end
        rdy[0] = 1'b1;
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        n_vec++; if ({vld[0], ovr[0]} !== 2'b00) begin n_err++; $display("FAIL ovr_accept got v/o %b want 00", {vld[0], ovr[0]}); end
        n_vec++; if (cap_data[0] !== 9'h011) begin n_err++; $display("FAIL ovr_accept_data got %h want 011", cap_data[0]); end
        rdy[0] = 1'b1;
    endtask

    task automatic test_wide_reset();
        int h2;
        h2 = hs_cnt[2];
        send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 2, 1'b1);
        repeat (20) @(posedge clk); #1;
        n_vec++; if (hs_cnt[2] - h2 != 1) begin n_err++; $display("FAIL wide_count got %0d want 1", hs_cnt[2] - h2); end
        n_vec++; if (cap_data[2] !== 9'h1FF || cap_ferr[2] !== 1'b0) begin n_err++; $display("FAIL wide_data got %h ferr %b want 1ff 0", cap_data[2], cap_ferr[2]); end
        n_vec++; if (d2 !== 9'h1FF) begin n_err++; $display("FAIL wide_held got %h want 1ff", d2); end
        // Second frame, abandoned by a reset in the middle of the data bits.
        drive_bit(2, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(2, 1'b1);
        n_vec++; if (bsy[2] !== 1'b1) begin n_err++; $display("FAIL wide_mid_busy got %b want 1", bsy[2]); end
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_vec++; if ({vld[2], perr[2], ferr[2], ovr[2], bsy[2]} !== 5'b0 || d2 !== 9'h000) begin n_err++; $display("FAIL wide_reset got data %h flags %b want 000 00000", d2, {vld[2], perr[2], ferr[2], ovr[2], bsy[2]}); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(2, 1'b1);
        n_vec++; if (hs_cnt[2] - h2 != 1 || vld[2] !== 1'b0) begin n_err++; $display("FAIL wide_no_word got %0d words valid %b want 1 0", hs_cnt[2] - h2, vld[2]); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            hs_cnt[i] = 0; vld_cyc[i] = 0; cap_data[i] = '0; cap_perr[i] = 1'b0; cap_ferr[i] = 1'b0;
        end
        rxd   = 3'b111;
        rdy   = 3'b111;
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_8n1();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_wide_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
